// File: rtl/spi_ram_pkg.sv
// Shared types and constants for the SPI RAM master.
//   op_e    : RAM command opcodes carried in cmd[9:8]
//   state_e : master frame sequencer states
//   CMD_W   : command word width, DATA_W : returned data width
package spi_ram_pkg;

  localparam int unsigned CMD_W  = 10;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    CTRL,
    SHIFT_CMD,
    TURN,
    SHIFT_RD,
    DONE
  } state_e;

  // Only read-data frames carry a MISO reply.
  function automatic logic is_read(op_e op);
    return op == OP_RD_DATA;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator. While en is high, an internal phase toggles every CLK_DIV
// clocks, so one SCLK period is 2*CLK_DIV clocks starting with the low half.
// sclk only follows the phase while gate is high, otherwise it is held low.
// Ports:
//   clk, rst     : system clock, async active-high reset
//   en           : run the half-period counter (cleared when low)
//   gate         : allow sclk to pulse in the current period
//   sclk         : registered SPI clock
//   rise_tick_c  : high in the clk before the phase goes high
//   fall_tick_c  : high in the clk before the phase goes low (period end)
module spi_clk_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic gate,
  output logic sclk,
  output logic rise_tick_c,
  output logic fall_tick_c
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] cnt;
  logic             phase;
  logic             wrap_c;

  assign wrap_c      = en && (cnt == DIV_W'(CLK_DIV - 1));
  assign rise_tick_c = wrap_c && !phase;
  assign fall_tick_c = wrap_c && phase;

  // Half-period counter and gated sclk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b0;
      sclk  <= 1'b0;
    end else if (!en) begin
      cnt   <= '0;
      phase <= 1'b0;
      sclk  <= 1'b0;
    end else if (wrap_c) begin
      cnt   <= '0;
      phase <= !phase;
      sclk  <= !phase && gate;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_ram_master.sv
// SPI mode-0 initiator for the SPI slave / RAM subsystem. Each accepted
// command is sent as one frame: a control bit (cmd[9]) then cmd[9:0] MSB
// first. Read-data frames add a turnaround and an 8-bit MISO reply.
// ss_n stays low through one trailing SCLK period after the last edge, then
// is high for one SCLK period before the master returns to IDLE.
// Ports:
//   clk, rst             : system clock, async active-high reset
//   cmd_valid/cmd_ready  : command handshake, cmd_data = {op, payload}
//   rd_data/rd_valid     : read-data reply and its one-clk strobe
//   busy                 : frame in progress
//   sclk, ss_n, mosi     : SPI outputs
//   miso                 : SPI input
module spi_ram_master
  import spi_ram_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned TURNAROUND = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [CMD_W-1:0]  cmd_data,
  output logic              cmd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              sclk,
  output logic              ss_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int unsigned CNT_MAX = (TURNAROUND > CMD_W) ? TURNAROUND : CMD_W;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_e            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CMD_W-1:0]  sh;
  logic [DATA_W-1:0] rd_shift;
  op_e               op_q;
  logic              accept_c, rise_c, fall_c, en_c, gate_c;

  assign accept_c = cmd_valid && cmd_ready;
  assign en_c     = (state != IDLE);
  assign gate_c   = (state == CTRL) || (state == SHIFT_CMD) || (state == SHIFT_RD);
  // mosi is the MSB of the command shift register, so it only moves on
  // load (sclk low) or on a falling-edge shift.
  assign mosi     = sh[CMD_W-1];

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk         (clk),
    .rst         (rst),
    .en          (en_c),
    .gate        (gate_c),
    .sclk        (sclk),
    .rise_tick_c (rise_c),
    .fall_tick_c (fall_c)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state; every state ends on a period-closing fall tick.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (accept_c) state_next = SELECT;
      SELECT:    if (fall_c) state_next = CTRL;
      CTRL:      if (fall_c) state_next = SHIFT_CMD;
      SHIFT_CMD: if (fall_c && cnt == CNT_W'(CMD_W - 1))
                   state_next = is_read(op_q) ? TURN : DONE;
      TURN:      if (fall_c && cnt == CNT_W'(TURNAROUND - 1)) state_next = SHIFT_RD;
      SHIFT_RD:  if (fall_c && cnt == CNT_W'(DATA_W - 1)) state_next = DONE;
      DONE:      if (fall_c && cnt == CNT_W'(1)) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      sh        <= '0;
      rd_shift  <= '0;
      op_q      <= OP_WR_ADDR;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      ss_n      <= 1'b1;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      cmd_ready <= (state_next == IDLE);
      busy      <= (state_next != IDLE);
      rd_valid  <= 1'b0;

      // Per-state period/bit counter.
      if (state_next != state) cnt <= '0;
      else if (fall_c)         cnt <= cnt + CNT_W'(1);

      case (state)
        IDLE: begin
          if (accept_c) begin
            sh       <= cmd_data;
            op_q     <= op_e'(cmd_data[CMD_W-1:CMD_W-2]);
            rd_shift <= '0;
            ss_n     <= 1'b0;
          end
        end
        SHIFT_CMD: begin
          if (fall_c) sh <= {sh[CMD_W-2:0], 1'b0};
        end
        SHIFT_RD: begin
          if (rise_c) rd_shift <= {rd_shift[DATA_W-2:0], miso};
          if (fall_c && cnt == CNT_W'(DATA_W - 1)) begin
            rd_data  <= rd_shift;
            rd_valid <= 1'b1;
          end
        end
        DONE: begin
          // First DONE period holds ss_n low; the second is the gap.
          if (fall_c && cnt == '0) ss_n <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_master.sv
// Bench for spi_ram_master: two instances (CLK_DIV=2 and CLK_DIV=1), each
// with a behavioural SPI slave + RAM, checked against a command-level model.
module tb_spi_ram_master;
  import spi_ram_pkg::*;

  localparam int DIV0 = 2;
  localparam int DIV1 = 1;
  localparam int TURN = 2;

  logic       clk = 1'b0;
  logic [1:0] rst;
  logic [1:0] cmd_valid;
  logic [9:0] cmd_data [2];
  logic [1:0] cmd_ready, rd_valid, busy, sclk, ss_n, mosi;
  logic [7:0] rd_data [2];
  logic       miso [2];

  // Exported monitor state, one entry per instance.
  int         frames_o [2];
  int         bits_o [2];
  int         last_low_o [2];
  int         min_gap_o [2];
  int         rv_o [2];
  int         viol_o [2];
  logic [10:0] l1_o [2];
  logic [10:0] l2_o [2];
  logic [10:0] l3_o [2];

  int checks = 0;
  int failures = 0;

  logic [7:0] ref_mem [2][256];
  logic [7:0] ref_addr [2];

  always #5 clk = ~clk;

  spi_ram_master #(.CLK_DIV(DIV0), .TURNAROUND(TURN)) u_dut0 (
    .clk(clk), .rst(rst[0]), .cmd_valid(cmd_valid[0]), .cmd_data(cmd_data[0]),
    .cmd_ready(cmd_ready[0]), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]),
    .busy(busy[0]), .sclk(sclk[0]), .ss_n(ss_n[0]), .mosi(mosi[0]), .miso(miso[0])
  );

  spi_ram_master #(.CLK_DIV(DIV1), .TURNAROUND(TURN)) u_dut1 (
    .clk(clk), .rst(rst[1]), .cmd_valid(cmd_valid[1]), .cmd_data(cmd_data[1]),
    .cmd_ready(cmd_ready[1]), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]),
    .busy(busy[1]), .sclk(sclk[1]), .ss_n(ss_n[1]), .mosi(mosi[1]), .miso(miso[1])
  );

  // Slave + RAM model and frame/handshake monitors.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    logic [7:0]  ram [256] = '{default: 8'h00};
    logic [7:0]  addr = 8'h00;
    logic [7:0]  rbyte = 8'h00;
    logic [10:0] sh = '0;
    logic [10:0] l1 = '0, l2 = '0, l3 = '0;
    logic        miso_s = 1'b0;
    logic        prev_mosi = 1'b0;
    logic        had_low = 1'b0;
    int          bits = 0, frames = 0, lowcnt = 0, highcnt = 0;
    int          last_low = 0, min_gap = 1000000, rv_cnt = 0, viol = 0;

    always @(posedge sclk[g] or posedge ss_n[g]) begin
      if (ss_n[g]) begin
        bits = 0;
        miso_s = 1'b0;
      end else if (bits < 11) begin
        sh = {sh[9:0], mosi[g]};
        bits++;
        if (bits == 11) begin
          l3 = l2; l2 = l1; l1 = sh;
          frames++;
          case (sh[9:8])
            2'b00, 2'b10: addr = sh[7:0];
            2'b01:        ram[addr] = sh[7:0];
            default: begin
              rbyte = ram[addr];
              miso_s = rbyte[7];
            end
          endcase
        end
      end else begin
        rbyte = {rbyte[6:0], 1'b0};
        @(negedge sclk[g] or posedge ss_n[g]);
        if (ss_n[g]) begin
          bits = 0;
          miso_s = 1'b0;
        end else begin
          miso_s = rbyte[7];
        end
      end
    end

    always @(negedge clk) begin
      if (!ss_n[g]) begin
        if (had_low && highcnt > 0 && highcnt < min_gap) min_gap = highcnt;
        highcnt = 0;
        lowcnt++;
        if (mosi[g] != prev_mosi && sclk[g]) viol++;
      end else begin
        if (lowcnt > 0) begin
          last_low = lowcnt;
          had_low = 1'b1;
        end
        lowcnt = 0;
        highcnt++;
      end
      prev_mosi = mosi[g];
      if (rd_valid[g]) begin
        rv_cnt++;
        if (cmd_ready[g]) viol++;
      end
    end

    assign miso[g]       = miso_s;
    assign frames_o[g]   = frames;
    assign bits_o[g]     = bits;
    assign last_low_o[g] = last_low;
    assign min_gap_o[g]  = min_gap;
    assign rv_o[g]       = rv_cnt;
    assign viol_o[g]     = viol;
    assign l1_o[g]       = l1;
    assign l2_o[g]       = l2;
    assign l3_o[g]       = l3;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int div_of(input int k);
    return (k == 0) ? DIV0 : DIV1;
  endfunction

  // ss_n-low length of a frame, from the command alone.
  function automatic int frame_clks(input int k, input logic [9:0] c);
    return 2 * div_of(k) * (13 + ((c[9:8] == 2'b11) ? (TURN + 8) : 0));
  endfunction

  // Apply a command to the RAM model; returns the expected read byte.
  function automatic logic [7:0] model_cmd(input int k, input logic [9:0] c);
    logic [7:0] r;
    r = ref_mem[k][ref_addr[k]];
    case (c[9:8])
      2'b00, 2'b10: ref_addr[k] = c[7:0];
      2'b01:        ref_mem[k][ref_addr[k]] = c[7:0];
      default: ;
    endcase
    return r;
  endfunction

  task automatic send_cmd(input int k, input logic [9:0] c,
                          output int got_low, output int got_rv, output logic [7:0] got_rd);
    int f0, r0, n;
    logic [7:0] exp_rd;
    exp_rd = model_cmd(k, c);
    f0 = frames_o[k];
    r0 = rv_o[k];
    @(negedge clk);
    cmd_data[k] = c;
    cmd_valid[k] = 1'b1;
    n = 0;
    while (cmd_ready[k] !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check("cmd_accept", 32'(cmd_ready[k]), 32'd1);
    @(negedge clk);
    cmd_valid[k] = 1'b0;
    check("busy_set", 32'(busy[k]), 32'd1);
    n = 0;
    while (busy[k] !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
    check("busy_clear", 32'(busy[k]), 32'd0);
    check("cmd_ready_back", 32'(cmd_ready[k]), 32'd1);
    check("frame_count", 32'(frames_o[k] - f0), 32'd1);
    check("mosi_bits", 32'(l1_o[k]), 32'({c[9], c}));
    check("ss_low_clks", 32'(last_low_o[k]), 32'(frame_clks(k, c)));
    got_low = last_low_o[k];
    got_rv  = rv_o[k] - r0;
    got_rd  = rd_data[k];
    check("rd_valid_count", 32'(got_rv), (c[9:8] == 2'b11) ? 32'd1 : 32'd0);
    if (c[9:8] == 2'b11) check("rd_data_model", 32'(got_rd), 32'(exp_rd));
  endtask

  typedef struct {
    int          k;
    logic [9:0]  cmd;
    logic [10:0] bits;
    int          low;
    int          rv;
    logic [7:0]  rd;
  } vec_t;

  vec_t vecs [13];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lo, rv, n, f0, r0;
    logic [7:0] rd;
    logic [9:0] b2b [3];

    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 256; a++) ref_mem[k][a] = 8'h00;
      ref_addr[k] = 8'h00;
      cmd_data[k] = 10'h000;
    end
    cmd_valid = 2'b00;
    rst = 2'b11;

    vecs[0]  = '{0, 10'h0A5, 11'h0A5, 52, 0, 8'h00};
    vecs[1]  = '{0, 10'h010, 11'h010, 52, 0, 8'h00};
    vecs[2]  = '{0, 10'h13C, 11'h13C, 52, 0, 8'h00};
    vecs[3]  = '{0, 10'h210, 11'h610, 52, 0, 8'h00};
    vecs[4]  = '{0, 10'h300, 11'h700, 92, 1, 8'h3C};
    vecs[5]  = '{0, 10'h020, 11'h020, 52, 0, 8'h00};
    vecs[6]  = '{0, 10'h1A5, 11'h1A5, 52, 0, 8'h00};
    vecs[7]  = '{0, 10'h220, 11'h620, 52, 0, 8'h00};
    vecs[8]  = '{0, 10'h300, 11'h700, 92, 1, 8'hA5};
    vecs[9]  = '{1, 10'h010, 11'h010, 26, 0, 8'h00};
    vecs[10] = '{1, 10'h13C, 11'h13C, 26, 0, 8'h00};
    vecs[11] = '{1, 10'h210, 11'h610, 26, 0, 8'h00};
    vecs[12] = '{1, 10'h300, 11'h700, 46, 1, 8'h3C};

    // Reset values.
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_ss_n", 32'(ss_n[k]), 32'd1);
      check("rst_sclk", 32'(sclk[k]), 32'd0);
      check("rst_mosi", 32'(mosi[k]), 32'd0);
      check("rst_cmd_ready", 32'(cmd_ready[k]), 32'd0);
      check("rst_rd_valid", 32'(rd_valid[k]), 32'd0);
      check("rst_rd_data", 32'(rd_data[k]), 32'd0);
      check("rst_busy", 32'(busy[k]), 32'd0);
    end
    rst = 2'b00;
    @(negedge clk);
    for (int k = 0; k < 2; k++) check("ready_after_rst", 32'(cmd_ready[k]), 32'd1);

    // Directed table.
    for (int i = 0; i < 13; i++) begin
      send_cmd(vecs[i].k, vecs[i].cmd, lo, rv, rd);
      check("tbl_bits", 32'(l1_o[vecs[i].k]), 32'(vecs[i].bits));
      check("tbl_ss_low", 32'(lo), 32'(vecs[i].low));
      check("tbl_rv", 32'(rv), 32'(vecs[i].rv));
      if (vecs[i].rv == 1) check("tbl_rd_data", 32'(rd), 32'(vecs[i].rd));
    end

    // cmd_valid held across three commands; data changes while busy.
    b2b[0] = 10'h040; b2b[1] = 10'h199; b2b[2] = 10'h240;
    f0 = frames_o[0];
    @(negedge clk);
    cmd_data[0] = b2b[0];
    cmd_valid[0] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      n = 0;
      while (cmd_ready[0] !== 1'b1 && n < 400) begin @(negedge clk); n++; end
      check("b2b_ready", 32'(cmd_ready[0]), 32'd1);
      cmd_data[0] = b2b[j];
      rd = model_cmd(0, b2b[j]);
      @(negedge clk);
      cmd_data[0] = 10'($urandom);
    end
    n = 0;
    while (cmd_ready[0] !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    cmd_valid[0] = 1'b0;
    check("b2b_frames", 32'(frames_o[0] - f0), 32'd3);
    check("b2b_frame1", 32'(l3_o[0]), 32'({b2b[0][9], b2b[0]}));
    check("b2b_frame2", 32'(l2_o[0]), 32'({b2b[1][9], b2b[1]}));
    check("b2b_frame3", 32'(l1_o[0]), 32'({b2b[2][9], b2b[2]}));
    send_cmd(0, 10'h300, lo, rv, rd);
    check("b2b_readback", 32'(rd), 32'h99);

    // Reset in the middle of SHIFT_CMD of a read-data frame.
    r0 = rv_o[0];
    f0 = frames_o[0];
    @(negedge clk);
    cmd_data[0] = 10'h300;
    cmd_valid[0] = 1'b1;
    n = 0;
    while (busy[0] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    cmd_valid[0] = 1'b0;
    n = 0;
    while (bits_o[0] < 6 && n < 200) begin @(negedge clk); n++; end
    check("mid_bits_reached", 32'(bits_o[0] >= 6), 32'd1);
    rst[0] = 1'b1;
    #1;
    check("mid_rst_ss_n", 32'(ss_n[0]), 32'd1);
    check("mid_rst_sclk", 32'(sclk[0]), 32'd0);
    check("mid_rst_busy", 32'(busy[0]), 32'd0);
    repeat (3) @(negedge clk);
    rst[0] = 1'b0;
    #1;
    check("mid_rel_ready0", 32'(cmd_ready[0]), 32'd0);
    @(negedge clk);
    check("mid_rel_ready1", 32'(cmd_ready[0]), 32'd1);
    repeat (60) @(negedge clk);
    check("mid_no_rd_valid", 32'(rv_o[0] - r0), 32'd0);
    check("mid_no_frame", 32'(frames_o[0] - f0), 32'd0);
    check("mid_rd_data", 32'(rd_data[0]), 32'd0);

    // Randomised traffic against the RAM model.
    for (int i = 0; i < 40; i++) begin
      int k;
      logic [1:0] op;
      logic [7:0] pl;
      k  = int'($urandom_range(1, 0));
      op = 2'($urandom_range(3, 0));
      pl = op[0] ? 8'($urandom) : 8'($urandom_range(7, 0));
      send_cmd(k, {op, pl}, lo, rv, rd);
    end

    for (int k = 0; k < 2; k++) begin
      check("protocol_viol", 32'(viol_o[k]), 32'd0);
      check("min_gap", 32'(min_gap_o[k] >= 2 * div_of(k)), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_ram_master.md
Name: spi_ram_master

Overview:
- SPI initiator that drives the SPI slave / single-port RAM subsystem from the system side.
- Accepts 10-bit RAM command words over a valid/ready handshake and serialises each onto MOSI as one SPI frame.
- For read-data commands (cmd[9:8]=2'b11), it waits for the slave turnaround, deserialises the 8-bit MISO reply and returns it.
- Sits in the top-level testbench/SoC wrapper as the counterpart of the slave + RAM path.

Parameters:
- CLK_DIV, 2, system clocks per SCLK half-period; legal range >= 1.
- TURNAROUND, 2, idle SCLK periods between the last command bit and the first MISO sample on reads; legal range >= 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- cmd_valid  input  1  command word available.
- cmd_data  input  10  RAM command: [9:8] op (00 write-addr, 01 write-data, 10 read-addr, 11 read-data), [7:0] payload.
- cmd_ready  output  1  master can accept a command.
- rd_data  output  8  byte returned by the last read-data frame.
- rd_valid  output  1  one-clk pulse; rd_data is valid.
- busy  output  1  frame in progress.
- sclk  output  1  SPI clock, idles low.
- ss_n  output  1  active-low slave select.
- mosi  output  1  master-out data.
- miso  input  1  slave-out data.

Behaviour:
- Reset (async, rst=1): state IDLE; ss_n=1, sclk=0, mosi=0, cmd_ready=0, rd_valid=0, rd_data=8'h00, busy=0; clear all counters.
- cmd_ready=1 only in IDLE. A command is accepted when cmd_valid && cmd_ready on a clk edge; cmd_data is registered into a 10-bit shift register.
- SPI mode 0: mosi changes only while sclk is low (on its falling transition or before the first rise). Slave and master sample on sclk rising. sclk toggles when the half-period counter reaches CLK_DIV-1; the counter then wraps to 0.
- FSM states:
  - IDLE: on accept -> SELECT. ss_n=0 and busy=1 take effect on the accept edge.
  - SELECT: one SCLK period with sclk low. mosi = cmd[9] as the control bit. -> CTRL.
  - CTRL: one sclk pulse clocks out the control bit. -> SHIFT_CMD.
  - SHIFT_CMD: 10 sclk pulses, bits 9..0 MSB first; a bit counter counts 0..9. After the 10th falling edge: if op==2'b11 -> TURN, else -> DONE.
  - TURN: TURNAROUND sclk periods with sclk held low and mosi=0. -> SHIFT_RD.
  - SHIFT_RD: 8 sclk pulses; sample miso on each rising edge into rd_shift, MSB first. After the 8th falling edge: rd_data<=rd_shift and rd_valid pulses for 1 clk. -> DONE.
  - DONE: ss_n=1, sclk=0 for one full SCLK period (minimum inter-frame gap). -> IDLE, where busy=0.
- Frame length in clk cycles:
  - Non-read: 2*CLK_DIV*(1+1+10+1).
  - Read-data: add 2*CLK_DIV*(TURNAROUND+8).
- cmd_valid asserted while busy is ignored. The master holds no queue; the upstream side must keep cmd_valid high until cmd_ready.
- Back-to-back commands: the next accept happens on the first IDLE clk. No command is dropped if cmd_valid is held.
- rd_valid never coincides with cmd_ready=1.
- Reset mid-frame: ss_n returns to 1 and sclk to 0 immediately. No rd_valid is produced. Any partial rd_shift is discarded.
- The 10-bit shift register and 8-bit rd_shift never wrap. Counters are sized to $clog2 of their maximum terminal count plus 1.

Decomposition:
- Package spi_ram_pkg holds:
  - typedef enum for op codes: OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11.
  - The FSM state enum.
  - Constants CMD_W=10, DATA_W=8.
- One sub-module, spi_clk_gen: half-period counter producing sclk plus single-clk rise_tick and fall_tick strobes. Its enable comes from the FSM.

Test Plan:
- Reset asserted mid SHIFT_CMD (bit 5) -> ss_n=1 and sclk=0 in the same cycle; rd_valid stays 0; cmd_ready=1 one clk after rst deasserts.
- cmd_data=10'h0A5 (write-addr 0xA5), CLK_DIV=2 -> mosi sampled on rises = 0, then 0,0,1,0,1,0,0,1,0,1; ss_n low for 52 clk; no rd_valid.
- Full write/read pair: write-addr 0x10, write-data 0x3C, read-addr 0x10, read-data 0x00, with slave model/RAM attached -> rd_data=8'h3C with a single rd_valid pulse.
- Read-data with the miso model driving 8'hA5 after TURNAROUND=2 -> rd_data=8'hA5; ss_n low for exactly 2*2*(13+10)=92 clk.
- cmd_valid held high across 3 commands -> exactly 3 frames; ss_n high for at least 2*CLK_DIV clk between frames; cmd_data changed while busy is not sampled.
- CLK_DIV=1 corner -> sclk toggles every clk; bit order and rd_data are still correct (rerun the read-back scenario).
